// File: rtl/arith_left_shift_sat_serial.sv
// ============================================================================
// arith_left_shift_sat_serial: serial signed a*2^s (one bit per clock) with
// sticky overflow detection. Saturation enabled by ARITH_LSHIFT_SATURATE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arith_left_shift_sat_serial #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [SW-1:0] s,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  res,
  output logic          ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  state_t        state;
  logic [N-1:0]  acc;
  logic [SW-1:0] cnt;
  logic          ovf_st;

  logic [N-1:0]  acc_shl;
  logic          ovf_next;
  logic [N-1:0]  fin;

  // Any shift that moves a bit differing from the sign into the MSB overflows.
  assign acc_shl  = {acc[N-2:0], 1'b0};
  assign ovf_next = ovf_st | (acc[N-1] ^ acc[N-2]);

`ifdef ARITH_LSHIFT_SATURATE_EN
  logic sign;
  assign fin = ovf_next ? (sign ? MIN_NEG : MAX_POS) : acc_shl;
`else
  assign fin = acc_shl;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf_st    <= 1'b0;
`ifdef ARITH_LSHIFT_SATURATE_EN
      sign      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            acc      <= a;
            cnt      <= s;
            ovf_st   <= 1'b0;
`ifdef ARITH_LSHIFT_SATURATE_EN
            sign     <= a[N-1];
`endif
            in_ready <= 1'b0;
            if (s == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
              res       <= a;
              ovf       <= 1'b0;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          acc    <= acc_shl;
          cnt    <= cnt - SW'(1);
          ovf_st <= ovf_next;
          if (cnt == SW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            res       <= fin;
            ovf       <= ovf_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arith_left_shift_sat_serial.sv
// ============================================================================
// tb_arith_left_shift_sat_serial: directed + random checks against an
// integer-arithmetic model of a*2^s with overflow and optional saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_arith_left_shift_sat_serial;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  a = '0;
  logic [SW-1:0] s = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N-1:0]  res;
  logic          ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] res;
    logic         ovf;
    int           due;
  } exp_t;
  exp_t q[$];

  arith_left_shift_sat_serial #(.N(N), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .s(s),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Exact product in wide integer arithmetic, then range check.
  function automatic logic [N:0] model(input logic [N-1:0] av, input int sv);
    longint p, lo, hi;
    logic   o;
    logic [N-1:0] r;
    p  = longint'($signed(av)) * (longint'(1) << sv);
    hi = (longint'(1) << (N-1)) - 1;
    lo = -(longint'(1) << (N-1));
    o  = (p > hi) || (p < lo);
    r  = p[N-1:0];
`ifdef ARITH_LSHIFT_SATURATE_EN
    if (o) r = (p < 0) ? N'(lo) : N'(hi);
`endif
    return {o, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Model bookkeeping on the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid && in_ready) begin
        exp_t e;
        logic [N:0] m;
        m     = model(a, int'(s));
        e.res = m[N-1:0];
        e.ovf = m[N];
        e.due = cyc + 1 + int'(s);
        q.push_back(e);
      end
    end
  end

  // Single compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_res", 32'(res), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(q.size() == 0));
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        chk("early_out_valid", 32'(cyc >= q[0].due), 32'd1);
        chk("res", 32'(res), 32'(q[0].res));
        chk("ovf", 32'(ovf), 32'(q[0].ovf));
      end else begin
        chk("late_out_valid", 32'(cyc < q[0].due), 32'd1);
      end
    end
  end

  task automatic do_op(input logic [N-1:0] av, input int sv, input int hold,
                       input logic [N-1:0] er, input logic eo, input bit lit);
    int n;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = av; s = SW'(sv);
    @(posedge clk); #1;
    in_valid = 1'b0; a = N'($urandom); s = SW'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("wait_out_valid", 32'(out_valid), 32'd1);
    if (lit) begin
      chk("lit_res", 32'(res), 32'(er));
      chk("lit_ovf", 32'(ovf), 32'(eo));
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      if (lit) chk("hold_res", 32'(res), 32'(er));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [N:0] m;
    // Pin the model with hand-computed values.
    m = model(8'h05, 3); chk("model_05_3", 32'(m), 32'h028);
    m = model(8'hF0, 3); chk("model_F0_3", 32'(m), 32'h080);
    m = model(8'hFF, 7); chk("model_FF_7", 32'(m), 32'h080);
`ifdef ARITH_LSHIFT_SATURATE_EN
    m = model(8'h20, 2); chk("model_20_2", 32'(m), 32'h17F);
    m = model(8'hC0, 2); chk("model_C0_2", 32'(m), 32'h180);
`else
    m = model(8'h20, 2); chk("model_20_2", 32'(m), 32'h180);
    m = model(8'hC0, 2); chk("model_C0_2", 32'(m), 32'h100);
`endif

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(8'h05, 3, 0, 8'h28, 1'b0, 1'b1);
    do_op(8'hF0, 3, 0, 8'h80, 1'b0, 1'b1);
`ifdef ARITH_LSHIFT_SATURATE_EN
    do_op(8'h20, 2, 0, 8'h7F, 1'b1, 1'b1);
    do_op(8'hC0, 2, 0, 8'h80, 1'b1, 1'b1);
`else
    do_op(8'h20, 2, 0, 8'h80, 1'b1, 1'b1);
    do_op(8'hC0, 2, 0, 8'h00, 1'b1, 1'b1);
`endif
    do_op(8'h00, 7, 0, 8'h00, 1'b0, 1'b1);
    do_op(8'h81, 0, 0, 8'h81, 1'b0, 1'b1);
    do_op(8'h03, 1, 5, 8'h06, 1'b0, 1'b1);

    // Abort an operation mid-shift.
    out_ready = 1'b1;
    in_valid = 1'b1; a = 8'h11; s = 3'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_res", 32'(res), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    do_op(8'h01, 1, 0, 8'h02, 1'b0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      int idle;
      do_op(N'($urandom), int'($urandom_range(0, (1 << SW) - 1)),
            int'($urandom_range(0, 3)), '0, 1'b0, 1'b0);
      idle = int'($urandom_range(0, 2));
      repeat (idle) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
